// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, reset polarity, FSM encodings and queue entry layout for the
// instruction-fetch queue.
package inst_fetch_queue_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  // Active level of rst for this block (low resets)
  localparam logic RstEnable = 1'b0;

  // Response-handling states
  localparam logic [0:0] FQ_RUN   = 1'b0;
  localparam logic [0:0] FQ_DRAIN = 1'b1;

  // One queue slot: fetch address, fetched word, word-has-arrived flag
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
    logic                   filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_entry_ram.sv
// DEPTH x 65-bit entry storage for the fetch queue.
// Ports: clk/rst; alloc_* writes pc and clears filled at the tail;
// fill_* writes the instruction and sets filled; head_idx/head_entry read
// the decode-facing entry combinationally.
module fetch_entry_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [PTR_W-1:0]       alloc_idx,
  input  logic [InstAddrBus-1:0] alloc_pc,
  input  logic                   fill_en,
  input  logic [PTR_W-1:0]       fill_idx,
  input  logic [InstBus-1:0]     fill_inst,
  input  logic [PTR_W-1:0]       head_idx,
  output fq_entry_t              head_entry
);

  fq_entry_t entries_q [DEPTH];
  fq_entry_t entries_d [DEPTH];

  // Alloc and fill never target the same slot: fill only hits already-allocated entries
  always_comb begin
    entries_d = entries_q;
    if (alloc_en) begin
      entries_d[alloc_idx].pc     = alloc_pc;
      entries_d[alloc_idx].filled = 1'b0;
    end
    if (fill_en) begin
      entries_d[fill_idx].inst   = fill_inst;
      entries_d[fill_idx].filled = 1'b1;
    end
  end

  // Clearing everything on reset makes id_pc/id_inst read 0 out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  assign head_entry = entries_q[head_idx];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch queue between pc_reg and IF/ID.
// Ports: clk, rst (async, active-low); pc/ce from pc_reg, fetch_stall back;
// inst_req/inst_addr/inst_gnt request channel; inst_rvalid/inst_rdata in-order
// responses; id_valid/id_pc/id_inst/id_ready decode handshake; flush discards
// the queue and every response still in flight.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc,
  input  logic                   ce,
  output logic                   fetch_stall,
  output logic                   inst_req,
  output logic [InstAddrBus-1:0] inst_addr,
  input  logic                   inst_gnt,
  input  logic                   inst_rvalid,
  input  logic [InstBus-1:0]     inst_rdata,
  output logic                   id_valid,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  input  logic                   id_ready,
  input  logic                   flush
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
  logic [0:0]       state_q, state_d;

  fq_entry_t head_entry;
  logic      alloc, fill, pop, in_rst;

  // Issue, stall and decode-side handshake
  always_comb begin
    in_rst      = (rst == RstEnable);
    inst_req    = ~in_rst & ce & ~flush & (count_q < CNT_W'(DEPTH));
    alloc       = inst_req & inst_gnt;
    fetch_stall = ~in_rst & ce & ~alloc;
    inst_addr   = pc;
    id_valid    = (count_q != '0) & head_entry.filled;
    id_pc       = head_entry.pc;
    id_inst     = head_entry.inst;
    pop         = id_valid & id_ready & ~flush;
    // Responses owed to pre-flush requests are swallowed while draining
    fill        = inst_rvalid & ~flush & (state_q == FQ_RUN);
  end

  // Pointer, occupancy and drain bookkeeping
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    drop_d  = drop_q;
    state_d = state_q;
    outst_d = outst_q + CNT_W'(alloc) - CNT_W'(inst_rvalid);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      // A response arriving in the flush cycle is already accounted for
      drop_d  = outst_q - CNT_W'(inst_rvalid);
      state_d = (drop_d != '0) ? FQ_DRAIN : FQ_RUN;
    end else begin
      if (alloc) tail_d = tail_q + PTR_W'(1);
      if (fill)  fill_d = fill_q + PTR_W'(1);
      if (pop)   head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      if ((state_q == FQ_DRAIN) && inst_rvalid) begin
        drop_d = drop_q - CNT_W'(1);
        if (drop_d == '0) state_d = FQ_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      state_q <= FQ_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  fetch_entry_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc),
    .alloc_idx  (tail_q),
    .alloc_pc   (pc),
    .fill_en    (fill),
    .fill_idx   (fill_q),
    .fill_inst  (inst_rdata),
    .head_idx   (head_q),
    .head_entry (head_entry)
  );

endmodule
